bcd_display_scan: RTL and testbench

Multiplexed 4-digit 7-segment display driver that consumes the packed BCD result of the binary-to-BCD converter ({MIL, CENT, DEC, UNIT}) and its DONE flag. Captures a new value on each rising edge of DONE and time-multiplexes the four digits onto a shared segment bus with one anode strobe per digit. Sits directly downstream of the BCD converter, driving the board's display pins.

---
 rtl/bcd_display_scan.sv | 110 +++++++++++
 tb/tb_bcd_display_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - multiplexed 4-digit 7-segment driver fed by a packed BCD converter result
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_display_scan #(
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] bcd_in,
  input  logic        done_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        bcd_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic          done_q;
  logic [15:0]   disp_q, disp_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic       capture;
  logic       tick;
  logic       blank;
  logic [3:0] nib;
  logic [6:0] seg_hi;
  logic [3:0] an_hi;

  always_comb begin
    capture = done_in & ~done_q;
    disp_d  = capture ? bcd_in : disp_q;
    tick    = (pcnt_q == PLAST) & en;
    pcnt_d  = pcnt_q;
    dig_d   = dig_q;
    if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      if (tick) dig_d = dig_q + 2'd1;
    end

    // Outputs are driven from the registered value and index, so a capture
    // or digit advance becomes visible one edge later.
    nib = disp_q[{dig_q, 2'b00} +: 4];
    case (nib)
      4'd0:    seg_hi = 7'b0111111;
      4'd1:    seg_hi = 7'b0000110;
      4'd2:    seg_hi = 7'b1011011;
      4'd3:    seg_hi = 7'b1001111;
      4'd4:    seg_hi = 7'b1100110;
      4'd5:    seg_hi = 7'b1101101;
      4'd6:    seg_hi = 7'b1111101;
      4'd7:    seg_hi = 7'b0000111;
      4'd8:    seg_hi = 7'b1111111;
      4'd9:    seg_hi = 7'b1101111;
      default: seg_hi = 7'b1000000;
    endcase

    blank = 1'b0;
`ifdef BCD_SCAN_LZB_EN
    // Nibbles above 9 are non-zero, so an invalid digit is never blanked.
    case (dig_q)
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      2'd2:    blank = (disp_q[15:8] == 8'd0);
      2'd1:    blank = (disp_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif

    an_hi = (en & ~blank) ? (4'b0001 << dig_q) : 4'b0000;
    seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d  = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    err_d = (disp_q[3:0] > 4'd9) | (disp_q[7:4] > 4'd9) |
            (disp_q[11:8] > 4'd9) | (disp_q[15:12] > 4'd9);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      done_q <= 1'b0;
      disp_q <= '0;
      pcnt_q <= '0;
      dig_q  <= '0;
      err_q  <= 1'b0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
    end else begin
      done_q <= done_in;
      disp_q <= disp_d;
      pcnt_q <= pcnt_d;
      dig_q  <= dig_d;
      err_q  <= err_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - randomized and directed bench with a behavioural display model
module tb_bcd_display_scan;

  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        en;
  logic        done_in;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        bcd_err;

  always #5 CLK = ~CLK;

  bcd_display_scan #(
    .PRESCALE(P),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .en(en),
    .bcd_in(bcd_in),
    .done_in(done_in),
    .seg(seg),
    .an(an),
    .bcd_err(bcd_err)
  );

  int total = 0;
  int passed = 0;

  // Model: shown value, previous DONE level, and position within one refresh.
  logic [15:0] m_disp;
  logic        m_done;
  int          m_pos;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_err;
  logic [6:0]  seg_tab [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    return 4'((v >> (4 * d)) & 16'h000F);
  endfunction

  function automatic bit blanked(input logic [15:0] v, input int d);
`ifdef BCD_SCAN_LZB_EN
    if (d == 0) return 1'b0;
    return (v >> (4 * d)) == 16'h0000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic r, input logic e, input logic d, input logic [15:0] b);
    int dg;
    reset = r; en = e; done_in = d; bcd_in = b;
    if (r) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_err = 1'b0;
      m_disp = '0; m_done = 1'b0; m_pos = 0;
    end else begin
      dg = m_pos / P;
      exp_an  = (e && !blanked(m_disp, dg)) ? ~(4'(1) << dg) : 4'hF;
      exp_seg = ~seg_tab[nib(m_disp, dg)];
      exp_err = 1'b0;
      for (int k = 0; k < 4; k++) if (nib(m_disp, k) > 4'd9) exp_err = 1'b1;
      if (d && !m_done) m_disp = b;
      m_done = d;
      if (e) m_pos = (m_pos + 1) % (4 * P);
    end
    @(negedge CLK);
    check("an", {28'd0, an}, {28'd0, exp_an});
    check("seg", {25'd0, seg}, {25'd0, exp_seg});
    check("bcd_err", {31'd0, bcd_err}, {31'd0, exp_err});
  endtask

  initial begin
    logic        r, e, d;
    logic [15:0] b;
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    reset = 1'b1; en = 1'b0; done_in = 1'b0; bcd_in = '0;
    m_disp = '0; m_done = 1'b0; m_pos = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("rst_an_lit", {28'd0, an}, 32'hF);
    check("rst_seg_lit", {25'd0, seg}, 32'h7F);
    check("rst_err_lit", {31'd0, bcd_err}, 32'h0);

    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("first_an_lit", {28'd0, an}, 32'hE);
    check("first_seg_lit", {25'd0, seg}, {25'd0, 7'b1000000});

    // Aligned capture of 0x1234, then one full refresh.
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h1234);
      if (i == 1) begin
        check("dig0_an_lit", {28'd0, an}, 32'hE);
        check("dig0_seg_lit", {25'd0, seg}, {25'd0, 7'b0011001});
      end
      if (i == 4) check("dig1_seg_lit", {25'd0, seg}, {25'd0, 7'b0110000});
      if (i == 8) check("dig2_seg_lit", {25'd0, seg}, {25'd0, 7'b0100100});
      if (i == 12) begin
        check("dig3_an_lit", {28'd0, an}, 32'h7);
        check("dig3_seg_lit", {25'd0, seg}, {25'd0, 7'b1111001});
      end
    end

    step(1'b0, 1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 16'h5678);
    check("held_model_lit", {16'd0, m_disp}, 32'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h5678);
    step(1'b0, 1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h5678);

    step(1'b0, 1'b1, 1'b1, 16'h12A4);
    step(1'b0, 1'b1, 1'b0, 16'h12A4);
    check("err_set_lit", {31'd0, bcd_err}, 32'h1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h12A4);
    step(1'b0, 1'b1, 1'b1, 16'h0009);
    step(1'b0, 1'b1, 1'b0, 16'h0009);
    check("err_clr_lit", {31'd0, bcd_err}, 32'h0);

    step(1'b0, 1'b1, 1'b1, 16'h0042);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 16'h0042);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 1'b1, 16'h9876);
    for (int i = 0; i < 4 * P && (m_pos / P) != 2; i++) step(1'b0, 1'b1, 1'b0, 16'h9876);
    step(1'b0, 1'b1, 1'b0, 16'h9876);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h9876);
    check("en_off_an_lit", {28'd0, an}, 32'hF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h9876);

    for (int i = 0; i < 4 * P && (m_pos / P) != 3; i++) step(1'b0, 1'b1, 1'b0, 16'h9876);
    step(1'b0, 1'b1, 1'b0, 16'h9876);
    step(1'b1, 1'b1, 1'b0, 16'h9876);
    check("midrst_an_lit", {28'd0, an}, 32'hF);
    step(1'b0, 1'b1, 1'b0, 16'h9876);
    check("midrst_seg_lit", {25'd0, seg}, {25'd0, 7'b1000000});

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 3) == 0) ? ~done_in : done_in;
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = b & 16'h00FF;
        1: b = {4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        default: ;
      endcase
      step(r, e, d, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
